// File: rtl/xram_arb_pkg.sv
// Shared encodings for the two-master XDATA SRAM arbiter.
package xram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int M_MCU = 0;
    localparam int M_DMA = 1;
    localparam int CNT_W = 3;

endpackage

// File: rtl/xram_arb2_rr.sv
// Two-way arbiter pick: a lone requester wins, ties go to the master not
// granted last unless fixed priority favours master 0.
module rr_arb2
    import xram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       fix_pri,
    output logic [1:0] pick
);

    always_comb begin
        pick = 2'b00;
        if (req == 2'b11) begin
            pick = (fix_pri || last) ? 2'b01 : 2'b10;
        end else begin
            pick = req;
        end
    end

endmodule

// File: rtl/xram_arb2.sv
// Arbiter and access sequencer sharing one XDATA SRAM between the 8051 bus
// (master 0) and the PD packet-buffer DMA (master 1).
module xram_arb2
    import xram_arb_pkg::*;
#(
    parameter int unsigned WAIT_CYC = 0,
    parameter int unsigned FIX_PRI  = 0
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        m0_r,
    input  logic        m0_w,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdat,
    output logic [7:0]  m0_rdat,
    output logic        m0_ack,
    input  logic        m1_r,
    input  logic        m1_w,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdat,
    output logic [7:0]  m1_rdat,
    output logic        m1_ack,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [15:0] ram_a,
    output logic [7:0]  ram_d,
    input  logic [7:0]  ram_q,
    output logic [1:0]  gnt
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [15:0]        ram_a_q, ram_a_d;
    logic [7:0]         ram_d_q, ram_d_d;
    logic [1:0]         gnt_q, gnt_d;
    logic [1:0]         ack_q, ack_d;
    logic               last_q, last_d;
    logic [1:0]         req;
    logic [1:0]         pick;

    assign req = {m1_r | m1_w, m0_r | m0_w};

    rr_arb2 u_rr (
        .req     (req),
        .last    (last_q),
        .fix_pri (FIX_PRI != 0),
        .pick    (pick)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        ram_a_d = ram_a_q;
        ram_d_d = ram_d_q;
        gnt_d   = gnt_q;
        ack_d   = 2'b00;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                // The ack cycle is spent in IDLE but cannot grant, so a master
                // still holding its request there is not served twice.
                if ((ack_q == 2'b00) && (pick != 2'b00)) begin
                    gnt_d   = pick;
                    last_d  = pick[M_DMA];
                    ram_a_d = pick[M_DMA] ? m1_addr : m0_addr;
                    ram_d_d = pick[M_DMA] ? m1_wdat : m0_wdat;
                    we_d    = pick[M_DMA] ? m1_w    : m0_w;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (WAIT_CYC > 0) begin
                    cnt_d   = CNT_W'(WAIT_CYC - 1);
                    state_d = WAIT;
                end else begin
                    state_d = DONE;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                ack_d   = gnt_q;
                gnt_d   = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            ram_a_q <= '0;
            ram_d_q <= '0;
            gnt_q   <= 2'b00;
            ack_q   <= 2'b00;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            ram_a_q <= ram_a_d;
            ram_d_q <= ram_d_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            last_q  <= last_d;
        end
    end

    assign ram_ce  = (state_q == ACC);
    assign ram_we  = ram_ce & we_q;
    assign ram_a   = ram_a_q;
    assign ram_d   = ram_d_q;
    assign gnt     = gnt_q;
    assign m0_ack  = ack_q[M_MCU];
    assign m1_ack  = ack_q[M_DMA];
    assign m0_rdat = ram_q;
    assign m1_rdat = ram_q;

endmodule

// File: doc/xram_arb2.md
Name: xram_arb2

Overview:
- Two-master arbiter and sequencer for the single-port XDATA SRAM.
- Master 0 is the 8051 MCU memory bus; master 1 is the PD packet-buffer DMA engine.
- Grants one access at a time, latches address and data, and drives the SRAM strobes.
- Inserts programmable wait states and returns a one-cycle ack to the winning master.

Parameters:
- WAIT_CYC, 0, extra SRAM wait cycles per access (0..7).
- FIX_PRI, 0, 0 = round-robin between masters; 1 = master 0 always wins.

Ports:
- clk  in  1  system clock, rising edge.
- rstz  in  1  asynchronous active-low reset.
- m0_r  in  1  master 0 read request, held until m0_ack.
- m0_w  in  1  master 0 write request, held until m0_ack.
- m0_addr  in  16  master 0 address.
- m0_wdat  in  8  master 0 write data.
- m0_rdat  out  8  master 0 read data, valid when m0_ack=1.
- m0_ack  out  1  master 0 access-complete pulse.
- m1_r, m1_w, m1_addr, m1_wdat, m1_rdat, m1_ack: same as master 0, for master 1.
- ram_ce  out  1  SRAM chip enable, one cycle per access.
- ram_we  out  1  SRAM write enable, qualified by ram_ce.
- ram_a  out  16  SRAM address (latched).
- ram_d  out  8  SRAM write data (latched).
- ram_q  in  8  SRAM read data, valid from the cycle after ram_ce and held until the next ram_ce.
- gnt  out  2  one-hot current owner; 00 when IDLE.

Behaviour:
- Reset (rstz=0, async):
  - state=IDLE, ram_ce=0, ram_we=0, ram_a=0, ram_d=0, m0_ack=0, m1_ack=0, gnt=00.
  - last-granted=1, so master 0 wins the first tie.
  - Takes effect immediately, including mid-access; the interrupted access is dropped with no ack.
- Request: reqN = mN_r | mN_w. If both are high, the access is a write.
- FSM states: IDLE, ACC, WAIT, DONE.
  - IDLE: if any reqN, choose the winner, latch addr/wdat/we into ram_a/ram_d/we_q, set gnt, go to ACC.
  - ACC: ram_ce=1, ram_we=we_q. Go to WAIT if WAIT_CYC>0 (load cnt=WAIT_CYC-1), else go to DONE.
  - WAIT: decrement cnt. Go to DONE when cnt==0.
  - DONE: mN_ack=1 for the granted master only; then return to IDLE and clear gnt.
- Ack/gnt timing: mN_ack and gnt are decoded from registered state (no combinational path from requests).
- Latency: request first sampled at edge E0 → ack high in the cycle after edge E(2+WAIT_CYC).
  - WAIT_CYC=0: ack in the 3rd cycle after the request rises, including the request cycle.
- Read data: mN_rdat = ram_q. Valid in DONE; don't-care otherwise.
- Back-to-back: IDLE lasts at least one cycle between accesses. Each access costs 4+WAIT_CYC cycles.
  - A master must drop its request in the cycle after ack, or the still-high request is a new access.
- Arbitration is sampled only in IDLE.
  - FIX_PRI=0: on a tie, grant the master not granted last; a lone requester always wins.
  - FIX_PRI=1: master 0 wins every tie.
  - Update last-granted on each grant.
- Input changes: changes to mN_addr/mN_wdat after the grant have no effect on the current access.
- Request withdrawn: a request dropped before grant is ignored. A request dropped after grant still completes and acks.
- WAIT_CYC>7: unsupported; the counter is 3 bits.

Decomposition:
- Package xram_arb_pkg:
  - state encoding IDLE=2'd0, ACC=2'd1, WAIT=2'd2, DONE=2'd3;
  - master indices M_MCU=0, M_DMA=1;
  - constant CNT_W=3.
- Sub-module rr_arb2:
  - inputs req[1:0], last, fix_pri; output one-hot pick[1:0];
  - purely combinational, instantiated once.

Test Plan:
- Single read, WAIT_CYC=0: m0_r=1, m0_addr=16'h0123, ram_q=8'h5A → ram_ce=1 with ram_a=16'h0123 one cycle after the request is sampled; m0_ack=1 two cycles later with m0_rdat=8'h5A; m1_ack stays 0.
- Single write, WAIT_CYC=3: m1_w=1, m1_addr=16'h8000, m1_wdat=8'hC3 → ram_ce=ram_we=1 for exactly one cycle with ram_d=8'hC3; m1_ack asserted 5 cycles after the request is sampled.
- Tie, round-robin: m0_r and m1_r held high continuously, each master dropping for one cycle after its ack → grants alternate 01,10,01,10 starting with master 0.
  - FIX_PRI=1: every grant is 01 while m0_r stays high.
- Address hold: change m0_addr from 16'h0010 to 16'hFFFF one cycle after the grant → ram_a stays 16'h0010 through DONE.
- Reset mid-access: assert rstz=0 during WAIT → ram_ce=0, gnt=00, no ack. After release, the first tie goes to master 0.
- Read+write conflict: m0_r=m0_w=1, m0_wdat=8'h77 → write performed (ram_we=1, ram_d=8'h77); m0_ack after 2+WAIT_CYC cycles.
